fma_load_scheduler: RTL and testbench

FMA_LOAD_SCHEDULER -- requirements
Module: fma_load_scheduler

---
 rtl/fma_pkg.sv | 17 +
 rtl/fma_load_scheduler.sv | 133 +++++++++++++
 tb/tb_fma_load_scheduler.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared definitions for the FMA load scheduler.
// Holds the scheduler state encoding, the default operand width and
// lane count, and the default WAIT-state timeout.
package fma_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_FMA_COUNT    = 4;
    localparam int DEF_WAIT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

endpackage

// File: rtl/fma_load_scheduler.sv
// FMA load scheduler.
// Accepts a batch command, then streams FMA_COUNT packed {c,b,a} operand
// words into consecutive lanes of the memory buffer, pulsing per-lane
// valid strobes. It then waits for the buffer to report valid, spends one
// settle cycle while the buffer clears, and reports batch completion.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   cmd_valid_in/ready_out    batch command handshake
//   cmd_load_c_in             batch also loads the c operands
//   data_in/valid_in/ready_out operand word handshake, {c,b,a}, a in LSBs
//   abc_out                   lane operands, lane i at [3*WIDTH*i +: 3*WIDTH]
//   abc_valid_out             per-lane {c,b,a} strobes
//   buf_valid_in              buffer's abc_valid_out
//   busy_out                  not in IDLE
//   batch_done_out            one-cycle pulse per completed batch
//   batch_count_out           completed batch count (wraps)
//   error_out                 sticky protocol/timeout flag
module fma_load_scheduler
    import fma_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int FMA_COUNT    = DEF_FMA_COUNT,
    parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           cmd_valid_in,
    input  logic                           cmd_load_c_in,
    output logic                           cmd_ready_out,
    input  logic [3*WIDTH-1:0]             data_in,
    input  logic                           data_valid_in,
    output logic                           data_ready_out,
    output logic [FMA_COUNT*3*WIDTH-1:0]   abc_out,
    output logic [FMA_COUNT*3-1:0]         abc_valid_out,
    input  logic                           buf_valid_in,
    output logic                           busy_out,
    output logic                           batch_done_out,
    output logic [15:0]                    batch_count_out,
    output logic                           error_out
);

    localparam int LANE_W = 3 * WIDTH;
    localparam int SLOT_W = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;
    localparam int CNT_W  = $clog2(WAIT_TIMEOUT + 1);

    state_t             state;
    logic [SLOT_W-1:0]  slot;
    logic               load_c;
    logic [CNT_W-1:0]   wait_cnt;

    // Ready is withheld while reset is asserted so nothing handshakes
    // against a state that is about to be discarded.
    assign cmd_ready_out  = (state == ST_IDLE) && !rst_in;
    assign data_ready_out = (state == ST_LOAD) && !rst_in;
    assign busy_out       = (state != ST_IDLE);

    logic cmd_hs, data_hs;
    assign cmd_hs  = cmd_valid_in  && cmd_ready_out;
    assign data_hs = data_valid_in && data_ready_out;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= ST_IDLE;
            slot            <= '0;
            load_c          <= 1'b0;
            wait_cnt        <= '0;
            abc_out         <= '0;
            abc_valid_out   <= '0;
            batch_done_out  <= 1'b0;
            batch_count_out <= '0;
            error_out       <= 1'b0;
        end else begin
            // Strobes and done are single-cycle pulses by default.
            abc_valid_out  <= '0;
            batch_done_out <= 1'b0;

            // The buffer should only report valid once a full batch is
            // loaded; anything else is a protocol error, but it does not
            // disturb the batch in progress.
            if (buf_valid_in && state != ST_WAIT)
                error_out <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (cmd_hs) begin
                        load_c <= cmd_load_c_in;
                        slot   <= '0;
                        state  <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (data_hs) begin
                        for (int i = 0; i < FMA_COUNT; i++) begin
                            if (slot == SLOT_W'(i)) begin
                                abc_out[i*LANE_W +: LANE_W] <= data_in;
                                abc_valid_out[i*3 +: 3]     <= {load_c, 2'b11};
                            end
                        end
                        if (slot == SLOT_W'(FMA_COUNT - 1)) begin
                            wait_cnt <= '0;
                            state    <= ST_WAIT;
                        end else begin
                            slot <= slot + SLOT_W'(1);
                        end
                    end
                end

                ST_WAIT: begin
                    if (buf_valid_in) begin
                        batch_done_out  <= 1'b1;
                        batch_count_out <= batch_count_out + 16'd1;
                        state           <= ST_SETTLE;
                    end else if (wait_cnt == CNT_W'(WAIT_TIMEOUT - 1)) begin
                        error_out <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_SETTLE: begin
                    // Buffer clears internally during this cycle.
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fma_load_scheduler.sv
// Self-checking bench for fma_load_scheduler (WIDTH=4, FMA_COUNT=4).
// Table-driven batches, hand-written corner sequences, and randomized
// batches checked against a transaction-level model of lane contents,
// batch count and the sticky error flag.
module tb_fma_load_scheduler;

    localparam int W  = 4;
    localparam int N  = 4;
    localparam int LW = 3 * W;
    localparam int TO = 255;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_valid, cmd_load_c, cmd_ready;
    logic [LW-1:0]      data;
    logic               data_valid, data_ready;
    logic [N*LW-1:0]    abc;
    logic [N*3-1:0]     abc_valid;
    logic               buf_valid, busy, batch_done, error;
    logic [15:0]        batch_count;

    always #5 clk = ~clk;

    fma_load_scheduler #(.WIDTH(W), .FMA_COUNT(N), .WAIT_TIMEOUT(TO)) dut (
        .clk_in(clk), .rst_in(rst),
        .cmd_valid_in(cmd_valid), .cmd_load_c_in(cmd_load_c), .cmd_ready_out(cmd_ready),
        .data_in(data), .data_valid_in(data_valid), .data_ready_out(data_ready),
        .abc_out(abc), .abc_valid_out(abc_valid),
        .buf_valid_in(buf_valid), .busy_out(busy),
        .batch_done_out(batch_done), .batch_count_out(batch_count), .error_out(error)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Transaction-level model state.
    logic [N-1:0][LW-1:0] m_lanes;
    int                   m_count;
    logic                 m_err;

    typedef struct {
        logic                 load_c;
        logic [N-1:0][LW-1:0] w;
        logic [N-1:0][11:0]   strb;
    } vec_t;

    vec_t tbl[3];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] strobe(input int lane, input logic lc);
        logic [11:0] s;
        s = lc ? 12'h007 : 12'h003;
        return s << (3 * lane);
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_data_ready", data_ready, 0);
        tick();
        chk("rst_abc", abc, 0);
        chk("rst_abc_valid", abc_valid, 0);
        chk("rst_done", batch_done, 0);
        chk("rst_count", batch_count, 0);
        chk("rst_error", error, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);
        m_lanes = '0;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic do_cmd(input logic lc);
        int k;
        k = 0;
        while (!cmd_ready && k < 50) begin
            tick();
            k++;
        end
        chk("cmd_ready_wait", (k < 50), 1);
        cmd_valid  = 1'b1;
        cmd_load_c = lc;
        tick();
        cmd_valid  = 1'b0;
        chk("load_busy", busy, 1);
        chk("load_data_ready", data_ready, 1);
        chk("load_cmd_ready", cmd_ready, 0);
    endtask

    task automatic send_word(input logic [LW-1:0] w, input int lane, input logic lc, input int gap);
        for (int g = 0; g < gap; g++) begin
            data_valid = 1'b0;
            tick();
            chk("gap_strobe", abc_valid, 0);
            chk("gap_ready", data_ready, 1);
        end
        data_valid = 1'b1;
        data       = w;
        tick();
        data_valid = 1'b0;
        m_lanes[lane] = w;
        chk($sformatf("strobe_l%0d", lane), abc_valid, strobe(lane, lc));
        chk($sformatf("lane_l%0d", lane), abc[lane*LW +: LW], w);
    endtask

    // Called right after the last word; checks WAIT entry.
    task automatic check_wait_entry();
        chk("wait_busy", busy, 1);
        chk("wait_data_ready", data_ready, 0);
        chk("wait_abc", abc, m_lanes);
    endtask

    task automatic finish_batch(input int delay);
        for (int d = 0; d < delay; d++) begin
            tick();
            chk("wait_no_strobe", abc_valid, 0);
            chk("wait_no_done", batch_done, 0);
        end
        buf_valid = 1'b1;
        tick();
        buf_valid = 1'b0;
        m_count = (m_count + 1) & 16'hFFFF;
        chk("done_pulse", batch_done, 1);
        chk("done_count", batch_count, m_count);
        tick();
        chk("done_clear", batch_done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("err_model", error, m_err);
    endtask

    initial begin
        int k;
        logic err_before;
        rst = 1'b1; cmd_valid = 0; cmd_load_c = 0; data = '0; data_valid = 0; buf_valid = 0;
        m_lanes = '0; m_count = 0; m_err = 0;
        tick();

        tbl[0].load_c = 1'b0;
        tbl[0].w      = {12'h278, 12'h278, 12'h278, 12'h278};
        tbl[0].strb   = {12'h600, 12'h0C0, 12'h018, 12'h003};
        tbl[1].load_c = 1'b1;
        tbl[1].w      = {12'h978, 12'h978, 12'h978, 12'h978};
        tbl[1].strb   = {12'hE00, 12'h1C0, 12'h038, 12'h007};
        tbl[2].load_c = 1'b0;
        tbl[2].w      = {12'hABC, 12'h789, 12'h456, 12'h123};
        tbl[2].strb   = {12'h600, 12'h0C0, 12'h018, 12'h003};

        apply_reset();

        // Table batches, back-to-back words.
        for (int t = 0; t < 3; t++) begin
            do_cmd(tbl[t].load_c);
            for (int l = 0; l < N; l++) begin
                data_valid = 1'b1;
                data       = tbl[t].w[l];
                tick();
                data_valid = 1'b0;
                m_lanes[l] = tbl[t].w[l];
                chk($sformatf("tbl%0d_strobe%0d", t, l), abc_valid, tbl[t].strb[l]);
                chk($sformatf("tbl%0d_lane%0d", t, l), abc[l*LW +: LW], tbl[t].w[l]);
            end
            check_wait_entry();
            finish_batch(t);
        end

        // Data gap of 3 cycles after lane 1.
        do_cmd(1'b0);
        send_word(12'h111, 0, 1'b0, 0);
        send_word(12'h222, 1, 1'b0, 0);
        send_word(12'h333, 2, 1'b0, 3);
        send_word(12'h444, 3, 1'b0, 1);
        check_wait_entry();
        finish_batch(0);

        // WAIT timeout.
        do_cmd(1'b1);
        for (int l = 0; l < N; l++) send_word(LW'(l + 5), l, 1'b1, 0);
        check_wait_entry();
        k = 0;
        err_before = 1'b1;
        while (busy && k < 400) begin
            if (k == TO - 1) err_before = error;
            tick();
            k++;
        end
        m_err = 1'b1;
        chk("timeout_cycles", k, TO);
        chk("timeout_err_before", err_before, 0);
        chk("timeout_error", error, 1);
        chk("timeout_idle_ready", cmd_ready, 1);
        chk("timeout_count", batch_count, m_count);

        // buf_valid in IDLE: error stays set, state unchanged.
        buf_valid = 1'b1;
        tick();
        buf_valid = 1'b0;
        chk("idle_buf_busy", busy, 0);
        chk("idle_buf_err", error, 1);

        // Reset mid-LOAD after lane 2, then a full batch.
        apply_reset();
        do_cmd(1'b1);
        send_word(12'hA5A, 0, 1'b1, 0);
        send_word(12'h5A5, 1, 1'b1, 0);
        send_word(12'hF0F, 2, 1'b1, 0);
        apply_reset();
        do_cmd(1'b0);
        for (int l = 0; l < N; l++) send_word(LW'(12'h0F0 + l), l, 1'b0, 0);
        check_wait_entry();
        finish_batch(2);

        // Reset mid-WAIT.
        do_cmd(1'b0);
        for (int l = 0; l < N; l++) send_word(LW'(12'h321 * (l + 1)), l, 1'b0, 0);
        tick();
        apply_reset();

        // buf_valid during LOAD: error set, loading continues.
        do_cmd(1'b1);
        send_word(12'h135, 0, 1'b1, 0);
        buf_valid = 1'b1;
        tick();
        buf_valid = 1'b0;
        m_err = 1'b1;
        chk("load_buf_err", error, 1);
        chk("load_buf_busy", busy, 1);
        chk("load_buf_ready", data_ready, 1);
        chk("load_buf_strobe", abc_valid, 0);
        for (int l = 1; l < N; l++) send_word(LW'(12'h135 + l), l, 1'b1, 0);
        check_wait_entry();
        finish_batch(1);

        // Randomized batches.
        apply_reset();
        for (int b = 0; b < 25; b++) begin
            logic lc;
            lc = 1'($urandom_range(0, 1));
            do_cmd(lc);
            for (int l = 0; l < N; l++)
                send_word(LW'($urandom), l, lc, $urandom_range(0, 2));
            check_wait_entry();
            finish_batch($urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
        $fatal(1);
    end

endmodule
